// File: rtl/adc_rd_pkg.sv
// Shared types and constants for the ADC FIFO reader.
// The HDR0/HDR1 states only exist when ADC_RD_HDR_EN is defined.
package adc_rd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hD1;

`ifdef ADC_RD_HDR_EN
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        FETCH,
        WAITD,
        SEND,
        DONE
    } rd_state_t;
`else
    localparam int HDR_BYTES = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAITD,
        SEND,
        DONE
    } rd_state_t;
`endif

endpackage

// File: rtl/adc_fifo_reader.sv
// Reads FRAME_LEN samples from a standard-mode capture FIFO and streams them out over valid/ready.
// Define ADC_RD_HDR_EN to prefix every frame with two SYNC_BYTE header bytes.
module adc_fifo_reader
    import adc_rd_pkg::*;
#(
    parameter int FRAME_LEN = 256
) (
    input  logic       ad0_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    // Handshake: a byte moves when tx_valid and tx_ready are both high on a clock edge;
    // tx_data/tx_valid never change while tx_valid=1 and tx_ready=0.

    localparam int              CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    rd_state_t        state;
    rd_state_t        state_next;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic rd_en;
    logic load_sync;
    logic load_sample;
    logic drop_valid;
    logic cnt_inc;
    logic cnt_clr;
    logic done_pulse;

    assign accept = tx_valid & tx_ready;

    always_ff @(posedge ad0_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rd_en       = 1'b0;
        load_sync   = 1'b0;
        load_sample = 1'b0;
        drop_valid  = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        done_pulse  = 1'b0;

        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
`ifdef ADC_RD_HDR_EN
                    state_next = HDR0;
                    load_sync  = 1'b1;
`else
                    state_next = FETCH;
`endif
                end
            end
`ifdef ADC_RD_HDR_EN
            HDR0: begin
                // Second sync byte follows back-to-back; no FIFO access during the header.
                if (accept) begin
                    state_next = HDR1;
                    load_sync  = 1'b1;
                end
            end
            HDR1: begin
                if (accept) begin
                    state_next = FETCH;
                    drop_valid = 1'b1;
                end
            end
`endif
            FETCH: begin
                if (!fifo_empty) begin
                    rd_en      = 1'b1;
                    state_next = WAITD;
                end
            end
            WAITD: begin
                load_sample = 1'b1;
                state_next  = SEND;
            end
            SEND: begin
                if (accept) begin
                    drop_valid = 1'b1;
                    // The last sample leaves the counter at FRAME_LEN-1 so it can never wrap.
                    if (cnt == CNT_LAST) begin
                        state_next = DONE;
                    end else begin
                        cnt_inc    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ad0_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            if (load_sync) begin
                tx_data  <= SYNC_BYTE;
                tx_valid <= 1'b1;
            end else if (load_sample) begin
                tx_data  <= fifo_dout;
                tx_valid <= 1'b1;
            end else if (drop_valid) begin
                tx_valid <= 1'b0;
            end

            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign fifo_rd_en = rd_en;
    assign busy       = (state != IDLE);
    assign frame_done = done_pulse;

endmodule

// File: tb/tb_adc_fifo_reader.sv
// Self-checking bench for adc_fifo_reader (FRAME_LEN=4); works with or without ADC_RD_HDR_EN.
module tb_adc_fifo_reader;
    import adc_rd_pkg::*;

    localparam int FL     = 4;
    localparam int NBYTES = HDR_BYTES + FL;

    logic       ad0_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       frame_done;

    always #5 ad0_clk = ~ad0_clk;

    adc_fifo_reader #(.FRAME_LEN(FL)) dut (
        .ad0_clk    (ad0_clk),
        .rst_n      (rst_n),
        .start      (start),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] acc_log[$];
    int         acc_cyc[$];

    int rd_total    = 0;
    int v20_cycles  = 0;
    int last_acc_cyc = 0;
    int done_cyc    = 0;
    int done_total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Standard-mode FIFO: data one cycle after rd_en, empty flag updates on the clock.
    always @(posedge ad0_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Downstream: holds off sample 20 for five cycles when hold_req is set.
    logic hold_req = 1'b0;
    int   held     = 0;
    always @(posedge ad0_clk) begin
        #1;
        if (hold_req && held < 5 && tx_valid && tx_data == 8'd20) begin
            tx_ready = 1'b0;
            held++;
        end else begin
            tx_ready = 1'b1;
        end
        if (!hold_req) held = 0;
    end

    // Frame-level model: byte order from exp_q, busy window, done timing and read rules.
    logic       m_busy = 1'b0;
    logic       m_due  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       start_ok;
    logic       next_due;
    int         m_acc = 0;
    int         m_rd  = 0;

    always @(negedge ad0_clk) begin
        if (!rst_n) begin
            m_busy     = 1'b0;
            m_due      = 1'b0;
            prev_stall = 1'b0;
            m_acc      = 0;
            m_rd       = 0;
        end else begin
            chk("frame_done", frame_done, m_due);
            chk("busy", busy, m_busy);
            if (fifo_rd_en) begin
                rd_total++;
                chk("rd_while_valid", tx_valid, 0);
                chk("rd_when_empty", fifo_empty, 0);
                chk("rd_outside_frame", m_busy, 1);
`ifdef ADC_RD_HDR_EN
                chk("rd_before_hdr_done", (m_acc >= HDR_BYTES), 1);
`endif
                chk("rd_outstanding", m_rd, m_acc - HDR_BYTES);
                m_rd++;
            end
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_data == 8'd20) v20_cycles++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected_byte", tx_valid, 0);
                end else begin
                    chk("tx_byte", tx_data, exp_q.pop_front());
                end
                acc_log.push_back(tx_data);
                acc_cyc.push_back(cyc);
                last_acc_cyc = cyc;
                m_acc++;
            end
            if (frame_done) begin
                done_total++;
                done_cyc = cyc;
            end
            next_due = tx_valid && tx_ready && (m_acc == NBYTES);
            start_ok = start && !m_busy;
            if (m_due) begin
                m_busy = 1'b0;
                m_acc  = 0;
                m_rd   = 0;
            end
            if (start_ok) m_busy = 1'b1;
            m_due      = next_due;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(posedge ad0_clk);
        #1;
    endtask

    task automatic load_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        for (int i = 0; i < HDR_BYTES; i++) exp_q.push_back(SYNC_BYTE);
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        exp_q.push_back(s3);
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!frame_done && n < limit) begin
            tick();
            n++;
        end
        chk("frame_done_timeout", frame_done, 1);
        tick();
    endtask

    task automatic wait_tx(input logic [7:0] d, input int limit);
        int n;
        n = 0;
        while (!(tx_valid && tx_data == d) && n < limit) begin
            tick();
            n++;
        end
        chk("tx_wait_timeout", tx_valid && tx_data == d, 1);
    endtask

    task automatic chk_log(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] want[4];
        want[0] = s0; want[1] = s1; want[2] = s2; want[3] = s3;
        chk("log_len", acc_log.size(), NBYTES);
        if (acc_log.size() == NBYTES) begin
`ifdef ADC_RD_HDR_EN
            chk("log_hdr0", acc_log[0], 8'hD1);
            chk("log_hdr1", acc_log[1], 8'hD1);
`endif
            for (int i = 0; i < 4; i++) chk("log_sample", acc_log[HDR_BYTES + i], want[i]);
        end
    endtask

    initial begin
        int rd0;
        int v0;
        int d0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Plain frame with tx_ready held high
        fifo_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        rd0 = rd_total;
        pulse_start();
        wait_done(100);
        chk("t1_rd_pulses", rd_total - rd0, 4);
        chk_log(8'd10, 8'd20, 8'd30, 8'd40);
        chk("t1_done_delay", done_cyc - last_acc_cyc, 1);
        if (acc_cyc.size() == NBYTES)
            chk("t1_sample_spacing", acc_cyc[NBYTES-1] - acc_cyc[NBYTES-2], 3);
        chk("t1_exp_drained", exp_q.size(), 0);
        chk("t1_idle_after", busy, 0);

        // Backpressure on sample 20
        fifo_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        rd0 = rd_total;
        v0 = v20_cycles;
        hold_req = 1'b1;
        pulse_start();
        wait_done(200);
        hold_req = 1'b0;
        chk("t2_valid20_cycles", v20_cycles - v0, 6);
        chk("t2_rd_pulses", rd_total - rd0, 4);
        chk_log(8'd10, 8'd20, 8'd30, 8'd40);

        // FIFO runs dry after two samples, then refills
        fifo_q = '{8'd10, 8'd20};
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        rd0 = rd_total;
        pulse_start();
        wait_tx(8'd20, 100);
        repeat (8) tick();
        chk("t3_stall_rd_pulses", rd_total - rd0, 2);
        chk("t3_stall_busy", busy, 1);
        fifo_q.push_back(8'd30);
        fifo_q.push_back(8'd40);
        wait_done(100);
        chk("t3_rd_pulses", rd_total - rd0, 4);
        chk_log(8'd10, 8'd20, 8'd30, 8'd40);

        // Reset mid-frame while sample 20 is on offer
        fifo_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        pulse_start();
        wait_tx(8'd20, 100);
        d0 = done_total;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_tx_valid", tx_valid, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_tx_data", tx_data, 8'h00);
        chk("t4_rst_frame_done", frame_done, 0);
        chk("t4_rst_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        fifo_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t4_no_frame_done", done_total - d0, 0);
        chk("t4_idle_after_reset", busy, 0);
        fifo_q = '{8'd50, 8'd60, 8'd70, 8'd80};
        load_frame(8'd50, 8'd60, 8'd70, 8'd80);
        pulse_start();
        wait_done(100);
        chk_log(8'd50, 8'd60, 8'd70, 8'd80);

        // Extra start pulses while busy must not lengthen the frame
        fifo_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd90, 8'd91};
        load_frame(8'd10, 8'd20, 8'd30, 8'd40);
        rd0 = rd_total;
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        wait_done(100);
        repeat (4) tick();
        chk("t5_rd_pulses", rd_total - rd0, 4);
        chk("t5_fifo_left", fifo_q.size(), 2);
        chk("t5_idle_after", busy, 0);
        chk_log(8'd10, 8'd20, 8'd30, 8'd40);
        fifo_q.delete();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_fifo_reader.md
ADC_FIFO_READER -- requirements
Module: adc_fifo_reader

Interface
REQ-001 Parameter FRAME_LEN, default 256: number of ADC samples read from the FIFO and transmitted per frame, range 2..4096.
REQ-002 Port ad0_clk  input  1  the sole clock.
REQ-003 Port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 Port start  input  1  single-cycle pulse that arms one frame.
REQ-005 Port fifo_dout  input  8  sample word from the capture FIFO.
REQ-006 Port fifo_empty  input  1  FIFO empty flag.
REQ-007 Port fifo_rd_en  output  1  FIFO read strobe; data arrives one cycle later (standard-mode FIFO).
REQ-008 Port tx_data  output  8  byte offered downstream.
REQ-009 Port tx_valid  output  1  tx_data is valid.
REQ-010 Port tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, HDR0, HDR1, FETCH, WAITD, SEND and DONE.
REQ-014 In IDLE, start=1 SHALL move the FSM to HDR0 when the header is compiled in, and to FETCH otherwise; start outside IDLE SHALL be ignored.
REQ-015 FETCH SHALL assert fifo_rd_en combinationally only when fifo_empty=0 and SHALL go to WAITD in that cycle; while fifo_empty=1 it SHALL stay in FETCH with fifo_rd_en=0.
REQ-016 WAITD SHALL register fifo_dout into tx_data, set tx_valid=1 and go to SEND, for a read-to-valid latency of exactly 2 cycles.
REQ-017 In SEND, tx_data and tx_valid SHALL stay stable until tx_ready=1.
REQ-018 On the accept cycle (tx_valid and tx_ready both 1), SEND SHALL clear tx_valid and increment the sample counter.
REQ-019 On the accept cycle, SEND SHALL go to DONE when the counter equals FRAME_LEN-1, and to FETCH otherwise.
REQ-020 The sample counter width SHALL be $clog2(FRAME_LEN) bits, it SHALL clear on entry to IDLE, and it SHALL never wrap within a frame.
REQ-021 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-022 fifo_rd_en SHALL never be asserted while tx_valid=1, so at most one unread sample is outstanding.
REQ-023 The block SHALL never read from the FIFO outside FETCH.
REQ-024 An empty FIFO mid-frame SHALL stall the FSM in FETCH indefinitely without dropping or duplicating samples.
REQ-025 Maximum throughput SHALL be one sample per 3 cycles when tx_ready is held at 1.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, tx_data=8'h00, tx_valid=0, frame_done=0 and busy=0.
REQ-027 fifo_rd_en SHALL be 0 during reset.
REQ-028 A reset mid-frame SHALL abandon the frame without issuing frame_done, and no further FIFO read SHALL occur until the next start after reset release.

Configuration
REQ-029 With macro ADC_RD_HDR_EN defined, every frame SHALL start with two sync bytes 8'hD1, 8'hD1 (decimal 209) sent from HDR0 and HDR1, each under the valid/ready rules of REQ-017 to REQ-019 and without reading the FIFO.
REQ-030 Without ADC_RD_HDR_EN, HDR0 and HDR1 SHALL not exist, and a frame SHALL be exactly FRAME_LEN bytes.

Structure
REQ-031 Package adc_rd_pkg SHALL hold the state enumeration and the constant SYNC_BYTE = 8'hD1.
REQ-032 The block SHALL be a single module with no sub-module; the FSM, counter and output register all sit in adc_fifo_reader.

Verification
REQ-033 Bench with FRAME_LEN=4, header off, FIFO preloaded with 10,20,30,40 and tx_ready=1; start pulse -> bytes 10,20,30,40, exactly 4 fifo_rd_en pulses, and frame_done 1 cycle after the 4th accept.
REQ-034 Same bench with ADC_RD_HDR_EN defined -> bytes D1,D1,10,20,30,40 and no rd_en before the second header byte is accepted.
REQ-035 tx_ready held 0 for 5 cycles during sample 20 -> tx_data stays 20 and tx_valid stays 1 throughout, with no extra rd_en.
REQ-036 FIFO empty after 2 samples for 8 cycles, then refilled with 30,40 -> FSM stalls in FETCH, then outputs 30,40 with no loss or duplication.
REQ-037 rst_n pulsed low during SEND of sample 20 -> tx_valid=0 immediately, busy=0, no frame_done, and the next start begins a fresh frame.
REQ-038 start pulsed while busy=1 -> ignored, and the frame length is unchanged at 4.
